// File: rtl/cmlk_multi_gate_seq_if.sv
// ----------------------------------------------------------------------------
// cmlk_multi_gate_seq_if
//   Bundles the run control, configuration inputs and pulse outputs of the
//   multi-channel gate sequencer.
//   master : drives enable, load_param and cfg_*; observes the outputs.
//   slave  : the sequencer itself.
//
//   Handshake: there is no valid/ready pair here. load_param is a one-cycle
//   strobe that is always accepted; cfg_* only need to be stable on the
//   cycle load_param is high. param_pending reports whether a captured
//   shadow set is still waiting to become active.
//
//   dbg_state exposes the sequencer FSM state (0 = IDLE, 1 = RUN).
// ----------------------------------------------------------------------------
interface cmlk_multi_gate_seq_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int DECI_W = 16
);
  logic                    enable;
  logic                    load_param;
  logic [CNT_W-1:0]        cfg_frame_period;
  logic [CNT_W-1:0]        cfg_trig_width;
  logic [CNT_W-1:0]        cfg_laser_period;
  logic [CNT_W-1:0]        cfg_laser_width;
  logic [NUM_CH*CNT_W-1:0] cfg_gate_delay;
  logic [NUM_CH*CNT_W-1:0] cfg_gate_width;
  logic [CNT_W-1:0]        cfg_b_offset;
  logic [7:0]              cfg_step;
  logic [7:0]              cfg_step_m;
  logic [DECI_W-1:0]       cfg_bg_deci_n;

  logic                    trig_pulse;
  logic                    laser_pulse;
  logic [NUM_CH-1:0]       gate_pulse;
  logic [1:0]              frame_type;
  logic                    frame_start;
  logic                    param_pending;
  logic                    dbg_state;

  modport master (
    output enable, load_param,
    output cfg_frame_period, cfg_trig_width, cfg_laser_period, cfg_laser_width,
    output cfg_gate_delay, cfg_gate_width, cfg_b_offset,
    output cfg_step, cfg_step_m, cfg_bg_deci_n,
    input  trig_pulse, laser_pulse, gate_pulse, frame_type,
    input  frame_start, param_pending, dbg_state
  );

  modport slave (
    input  enable, load_param,
    input  cfg_frame_period, cfg_trig_width, cfg_laser_period, cfg_laser_width,
    input  cfg_gate_delay, cfg_gate_width, cfg_b_offset,
    input  cfg_step, cfg_step_m, cfg_bg_deci_n,
    output trig_pulse, laser_pulse, gate_pulse, frame_type,
    output frame_start, param_pending, dbg_state
  );
endinterface

// File: rtl/cmlk_multi_gate_seq.sv
// ----------------------------------------------------------------------------
// cmlk_multi_gate_seq
//   Frame / laser / multi-channel gate pulse sequencer for a gated camera.
//   A frame counter drives the camera trigger, a free-running laser phase
//   counter drives the laser pulse, and each gate channel opens a window
//   inside every laser period at a programmable delay. The delay can walk
//   forward within a frame, gets an extra offset in B frames, and frames
//   are labelled A / B / background with optional background decimation.
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : cmlk_multi_gate_seq_if.slave (run control, cfg_*, pulse outputs)
//
// All pulse outputs are registered decodes of the counter state, so every
// output for a given count shows up together one cycle after that count.
// ----------------------------------------------------------------------------
module cmlk_multi_gate_seq #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int DECI_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  cmlk_multi_gate_seq_if.slave bus
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [1:0] FT_BG = 2'b00;
  localparam logic [1:0] FT_A  = 2'b01;
  localparam logic [1:0] FT_B  = 2'b10;

  typedef struct packed {
    logic [CNT_W-1:0]        frame_period;
    logic [CNT_W-1:0]        trig_width;
    logic [CNT_W-1:0]        laser_period;
    logic [CNT_W-1:0]        laser_width;
    logic [NUM_CH*CNT_W-1:0] gate_delay;
    logic [NUM_CH*CNT_W-1:0] gate_width;
    logic [CNT_W-1:0]        b_offset;
    logic [7:0]              step;
    logic [7:0]              step_m;
    logic [DECI_W-1:0]       bg_deci_n;
  } param_t;

  param_t w_cfg;
  param_t r_shadow;
  param_t r_active;
  logic   r_pending;
  logic   w_xfer;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_run_on;

  logic [CNT_W-1:0]  r_frame_cnt;
  logic [CNT_W-1:0]  r_phase;
  logic [7:0]        r_wrap_cnt;
  logic [CNT_W-1:0]  r_offset;
  logic [DECI_W-1:0] r_bg_cnt;   // frame index modulo (bg_deci_n + 1)
  logic              r_is_b;     // A/B alternation for the current frame

  logic [CNT_W:0]    w_frame_inc;
  logic [CNT_W:0]    w_phase_inc;
  logic [8:0]        w_wrap_inc;
  logic [CNT_W:0]    w_offset_sum;
  logic              w_frame_last;
  logic              w_phase_last;
  logic              w_wrap_last;
  logic              w_is_bg;
  logic              w_laser_on;
  logic [CNT_W-1:0]  w_b_add;
  logic [NUM_CH-1:0] w_gate_hit;

  logic              w_trig_d;
  logic              w_laser_d;
  logic [NUM_CH-1:0] w_gate_d;
  logic [1:0]        w_ftype_d;
  logic              w_fstart_d;

  logic              r_trig_pulse;
  logic              r_laser_pulse;
  logic [NUM_CH-1:0] r_gate_pulse;
  logic [1:0]        r_frame_type;
  logic              r_frame_start;
  logic              r_param_pending;

  // ---------------------------------------------------------------- config
  always_comb begin
    w_cfg              = '0;
    w_cfg.frame_period = bus.cfg_frame_period;
    w_cfg.trig_width   = bus.cfg_trig_width;
    w_cfg.laser_period = bus.cfg_laser_period;
    w_cfg.laser_width  = bus.cfg_laser_width;
    w_cfg.gate_delay   = bus.cfg_gate_delay;
    w_cfg.gate_width   = bus.cfg_gate_width;
    w_cfg.b_offset     = bus.cfg_b_offset;
    w_cfg.step         = bus.cfg_step;
    w_cfg.step_m       = bus.cfg_step_m;
    w_cfg.bg_deci_n    = bus.cfg_bg_deci_n;
  end

  // The shadow set becomes active on the edge that takes the frame counter
  // back to 0, so the first count of the new frame already uses it.
  assign w_xfer = r_pending && ((r_state == S_IDLE) || w_frame_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (bus.load_param) r_shadow <= w_cfg;
      if (w_xfer)         r_active <= r_shadow;
      // A load on the transfer cycle leaves the newer set still pending.
      if (bus.load_param) r_pending <= 1'b1;
      else if (w_xfer)    r_pending <= 1'b0;
    end
  end

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.enable && (r_active.frame_period != '0)) w_state_nxt = S_RUN;
      S_RUN:  if (!bus.enable || (r_active.frame_period == '0)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_run_on = (r_state == S_RUN) && (w_state_nxt == S_RUN);

  // -------------------------------------------------------------- counters
  assign w_frame_inc  = {1'b0, r_frame_cnt} + (CNT_W+1)'(1);
  assign w_phase_inc  = {1'b0, r_phase} + (CNT_W+1)'(1);
  assign w_wrap_inc   = {1'b0, r_wrap_cnt} + 9'd1;
  assign w_offset_sum = {1'b0, r_offset} + {{(CNT_W+1-8){1'b0}}, r_active.step};
  assign w_frame_last = w_frame_inc >= {1'b0, r_active.frame_period};
  assign w_phase_last = w_phase_inc >= {1'b0, r_active.laser_period};
  assign w_wrap_last  = w_wrap_inc >= {1'b0, r_active.step_m};
  assign w_is_bg      = (r_active.bg_deci_n != '0) && (r_bg_cnt == r_active.bg_deci_n);
  assign w_laser_on   = r_active.laser_period != '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_phase     <= '0;
      r_wrap_cnt  <= '0;
      r_offset    <= '0;
      r_bg_cnt    <= '0;
      r_is_b      <= 1'b0;
    end else if (!w_run_on) begin
      r_frame_cnt <= '0;
      r_phase     <= '0;
      r_wrap_cnt  <= '0;
      r_offset    <= '0;
      r_bg_cnt    <= '0;
      r_is_b      <= 1'b0;
    end else if (w_frame_last) begin
      r_frame_cnt <= '0;
      r_phase     <= '0;
      r_wrap_cnt  <= '0;
      r_offset    <= '0;
      r_bg_cnt    <= ((r_active.bg_deci_n == '0) || (r_bg_cnt >= r_active.bg_deci_n))
                     ? '0 : r_bg_cnt + DECI_W'(1);
      // Background frames are skipped by the A/B alternation.
      if (!w_is_bg) r_is_b <= ~r_is_b;
    end else begin
      r_frame_cnt <= w_frame_inc[CNT_W-1:0];
      if (w_phase_last) begin
        r_phase <= '0;
        if (r_active.step_m != 8'd0) begin
          if (w_wrap_last) begin
            r_wrap_cnt <= '0;
            r_offset   <= w_offset_sum[CNT_W] ? '1 : w_offset_sum[CNT_W-1:0];
          end else begin
            r_wrap_cnt <= w_wrap_inc[7:0];
          end
        end
      end else begin
        r_phase <= w_phase_inc[CNT_W-1:0];
      end
    end
  end

  // ----------------------------------------------------------- gate decode
  assign w_b_add = (r_is_b && !w_is_bg) ? r_active.b_offset : '0;

  // Window arithmetic is two bits wider than a count so delay + offset +
  // b_offset + width never wraps; phase < laser_period truncates the window.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_gate
    logic [CNT_W-1:0] w_dly;
    logic [CNT_W-1:0] w_wid;
    logic [CNT_W+1:0] w_start;
    logic [CNT_W+2:0] w_end;
    assign w_dly   = r_active.gate_delay[gi*CNT_W +: CNT_W];
    assign w_wid   = r_active.gate_width[gi*CNT_W +: CNT_W];
    assign w_start = {2'b00, w_dly} + {2'b00, r_offset} + {2'b00, w_b_add};
    assign w_end   = {1'b0, w_start} + {3'b000, w_wid};
    assign w_gate_hit[gi] = ({3'b000, r_phase} >= {1'b0, w_start}) &&
                            ({3'b000, r_phase} < w_end);
  end

  // ---------------------------------------------------------- output decode
  always_comb begin
    w_trig_d   = 1'b0;
    w_laser_d  = 1'b0;
    w_gate_d   = '0;
    w_ftype_d  = FT_BG;
    w_fstart_d = 1'b0;
    if (r_state == S_RUN) begin
      w_trig_d   = r_frame_cnt < r_active.trig_width;
      w_laser_d  = w_laser_on && (r_phase < r_active.laser_width) && !w_is_bg;
      w_gate_d   = w_laser_on ? w_gate_hit : '0;
      w_ftype_d  = w_is_bg ? FT_BG : (r_is_b ? FT_B : FT_A);
      w_fstart_d = r_frame_cnt == '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trig_pulse    <= 1'b0;
      r_laser_pulse   <= 1'b0;
      r_gate_pulse    <= '0;
      r_frame_type    <= FT_BG;
      r_frame_start   <= 1'b0;
      r_param_pending <= 1'b0;
    end else begin
      r_trig_pulse    <= w_trig_d;
      r_laser_pulse   <= w_laser_d;
      r_gate_pulse    <= w_gate_d;
      r_frame_type    <= w_ftype_d;
      r_frame_start   <= w_fstart_d;
      // Delayed like the pulses so it drops on the frame_start cycle.
      r_param_pending <= r_pending;
    end
  end

  assign bus.trig_pulse    = r_trig_pulse;
  assign bus.laser_pulse   = r_laser_pulse;
  assign bus.gate_pulse    = r_gate_pulse;
  assign bus.frame_type    = r_frame_type;
  assign bus.frame_start   = r_frame_start;
  assign bus.param_pending = r_param_pending;
  assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_cmlk_multi_gate_seq.sv
module tb_cmlk_multi_gate_seq;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int DECI_W = 16;
  localparam int MAXP   = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] exp_q[$];

  cmlk_multi_gate_seq_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DECI_W(DECI_W)) bus ();

  cmlk_multi_gate_seq #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DECI_W(DECI_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------------------------------------------- clock / reset block
  always #5 clk = ~clk;

  // ----------------------------------------------------------- capture data
  logic [MAXP-1:0] cap_trig;
  logic [MAXP-1:0] cap_laser;
  logic [MAXP-1:0] cap_fs;
  logic [MAXP-1:0] cap_pend;
  logic [MAXP-1:0] cap_gate [NUM_CH];
  logic [1:0]      cap_ftype;

  function automatic int ones(input logic [MAXP-1:0] v, input int lo, input int hi);
    int c = 0;
    for (int n = lo; n <= hi; n++) if (v[n] === 1'b1) c++;
    return c;
  endfunction

  function automatic int first_one(input logic [MAXP-1:0] v, input int lo, input int hi);
    for (int n = lo; n <= hi; n++) if (v[n] === 1'b1) return n - lo;
    return -1;
  endfunction

  // ----------------------------------------------------------- driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_gate(input int ch, input int dly, input int wid);
    bus.cfg_gate_delay[ch*CNT_W +: CNT_W] = dly;
    bus.cfg_gate_width[ch*CNT_W +: CNT_W] = wid;
  endtask

  task automatic set_defaults();
    bus.cfg_frame_period = 1000;
    bus.cfg_trig_width   = 10;
    bus.cfg_laser_period = 100;
    bus.cfg_laser_width  = 5;
    bus.cfg_gate_delay   = '0;
    bus.cfg_gate_width   = '0;
    bus.cfg_b_offset     = 0;
    bus.cfg_step         = 0;
    bus.cfg_step_m       = 0;
    bus.cfg_bg_deci_n    = 0;
    set_gate(0, 20, 8);
  endtask

  // Stop, load the current cfg_* and start a fresh run (frame index 0).
  task automatic run_cfg();
    bus.enable = 1'b0;
    repeat (3) step();
    bus.load_param = 1'b1;
    step();
    bus.load_param = 1'b0;
    step();
    bus.enable = 1'b1;
  endtask

  // Wait (bounded) for frame_start, then record p samples; sample n is count n.
  task automatic capture_frame(input int p, input int load_at);
    int guard = 0;
    while (bus.frame_start !== 1'b1 && guard < 3000) begin
      step();
      guard++;
    end
    if (bus.frame_start !== 1'b1) begin
      total++; bad++;
      $display("FAIL frame_start_wait got=%b want=1 after %0d cycles", bus.frame_start, guard);
    end
    cap_trig = '0; cap_laser = '0; cap_fs = '0; cap_pend = '0;
    for (int c = 0; c < NUM_CH; c++) cap_gate[c] = '0;
    cap_ftype = bus.frame_type;
    for (int n = 0; n < p; n++) begin
      cap_trig[n]  = bus.trig_pulse;
      cap_laser[n] = bus.laser_pulse;
      cap_fs[n]    = bus.frame_start;
      cap_pend[n]  = bus.param_pending;
      for (int c = 0; c < NUM_CH; c++) cap_gate[c][n] = bus.gate_pulse[c];
      bus.load_param = (n == load_at);
      step();
    end
    bus.load_param = 1'b0;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    int fs_seen = 0;
    bus.enable = 1'b0; bus.load_param = 1'b0;
    set_defaults();
    bus.cfg_frame_period = 0;
    rst = 1'b1;
    repeat (3) step();
    total++; if (bus.trig_pulse !== 1'b0) begin bad++; $display("FAIL rst_trig got=%b want=0", bus.trig_pulse); end
    total++; if (bus.laser_pulse !== 1'b0) begin bad++; $display("FAIL rst_laser got=%b want=0", bus.laser_pulse); end
    total++; if (bus.gate_pulse !== 4'h0) begin bad++; $display("FAIL rst_gate got=%h want=0", bus.gate_pulse); end
    total++; if (bus.frame_type !== 2'b00) begin bad++; $display("FAIL rst_ftype got=%b want=00", bus.frame_type); end
    total++; if (bus.frame_start !== 1'b0) begin bad++; $display("FAIL rst_fstart got=%b want=0", bus.frame_start); end
    total++; if (bus.param_pending !== 1'b0) begin bad++; $display("FAIL rst_pending got=%b want=0", bus.param_pending); end
    rst = 1'b0;
    bus.enable = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (bus.frame_start === 1'b1 || bus.trig_pulse === 1'b1) fs_seen++;
      step();
    end
    total++; if (fs_seen !== 0) begin bad++; $display("FAIL rst_no_start got=%0d want=0", fs_seen); end
    bus.enable = 1'b0;
  endtask

  task automatic test_basic();
    int rises = 0;
    set_defaults();
    run_cfg();
    capture_frame(1000, -1);
    for (int n = 0; n < 1000; n++) if (cap_laser[n] && (n == 0 || !cap_laser[n-1])) rises++;
    total++; if (cap_ftype !== 2'b01) begin bad++; $display("FAIL basic_ftype got=%b want=01", cap_ftype); end
    total++; if (ones(cap_trig, 0, 999) !== 10) begin bad++; $display("FAIL basic_trig_cnt got=%0d want=10", ones(cap_trig, 0, 999)); end
    total++; if (cap_trig[0] !== 1'b1) begin bad++; $display("FAIL basic_trig_rise got=%b want=1", cap_trig[0]); end
    total++; if (cap_trig[10] !== 1'b0) begin bad++; $display("FAIL basic_trig_fall got=%b want=0", cap_trig[10]); end
    total++; if (rises !== 10) begin bad++; $display("FAIL basic_laser_rises got=%0d want=10", rises); end
    total++; if (ones(cap_laser, 0, 999) !== 50) begin bad++; $display("FAIL basic_laser_cnt got=%0d want=50", ones(cap_laser, 0, 999)); end
    total++; if (ones(cap_gate[0], 0, 999) !== 80) begin bad++; $display("FAIL basic_gate_cnt got=%0d want=80", ones(cap_gate[0], 0, 999)); end
    total++; if (cap_gate[0][19] !== 1'b0 || cap_gate[0][20] !== 1'b1) begin bad++; $display("FAIL basic_gate_open got=%b%b want=01", cap_gate[0][19], cap_gate[0][20]); end
    total++; if (cap_gate[0][27] !== 1'b1 || cap_gate[0][28] !== 1'b0) begin bad++; $display("FAIL basic_gate_close got=%b%b want=10", cap_gate[0][27], cap_gate[0][28]); end
    total++; if (ones(cap_gate[1], 0, 999) !== 0) begin bad++; $display("FAIL basic_gate1_zero_width got=%0d want=0", ones(cap_gate[1], 0, 999)); end
    total++; if (ones(cap_fs, 0, 999) !== 1) begin bad++; $display("FAIL basic_fstart_cnt got=%0d want=1", ones(cap_fs, 0, 999)); end
    total++; if (cap_pend[500] !== 1'b0) begin bad++; $display("FAIL basic_pending got=%b want=0", cap_pend[500]); end
    capture_frame(1000, -1);
    total++; if (cap_ftype !== 2'b10) begin bad++; $display("FAIL basic_ftype_b got=%b want=10", cap_ftype); end
    total++; if (cap_gate[0][120] !== 1'b1) begin bad++; $display("FAIL basic_gate_b got=%b want=1", cap_gate[0][120]); end
  endtask

  task automatic test_background();
    logic [1:0] want;
    int         want_laser;
    set_defaults();
    bus.cfg_frame_period = 200;
    bus.cfg_bg_deci_n    = 2;
    run_cfg();
    exp_q = {32'd1, 32'd2, 32'd0, 32'd1, 32'd2, 32'd0};
    for (int f = 0; f < 6; f++) begin
      capture_frame(200, -1);
      want = exp_q.pop_front();
      want_laser = (want == 2'b00) ? 0 : 10;
      total++; if (cap_ftype !== want) begin bad++; $display("FAIL bg_ftype frame=%0d got=%b want=%b", f, cap_ftype, want); end
      total++; if (ones(cap_laser, 0, 199) !== want_laser) begin bad++; $display("FAIL bg_laser frame=%0d got=%0d want=%0d", f, ones(cap_laser, 0, 199), want_laser); end
      total++; if (ones(cap_gate[0], 0, 199) !== 16) begin bad++; $display("FAIL bg_gate frame=%0d got=%0d want=16", f, ones(cap_gate[0], 0, 199)); end
    end
  endtask

  task automatic test_step();
    int exp_start [10] = '{20, 20, 23, 23, 26, 26, 29, 29, 32, 32};
    int got;
    set_defaults();
    bus.cfg_step   = 3;
    bus.cfg_step_m = 2;
    run_cfg();
    capture_frame(1000, -1);
    for (int j = 0; j < 10; j++) begin
      got = first_one(cap_gate[0], j*100, j*100 + 99);
      total++; if (got !== exp_start[j]) begin bad++; $display("FAIL step_start period=%0d got=%0d want=%0d", j, got, exp_start[j]); end
    end
    total++; if (ones(cap_gate[0], 0, 999) !== 80) begin bad++; $display("FAIL step_gate_cnt got=%0d want=80", ones(cap_gate[0], 0, 999)); end
    capture_frame(1000, -1);
    got = first_one(cap_gate[0], 0, 99);
    total++; if (got !== 20) begin bad++; $display("FAIL step_restart got=%0d want=20", got); end
    got = first_one(cap_gate[0], 200, 299);
    total++; if (got !== 23) begin bad++; $display("FAIL step_second_frame got=%0d want=23", got); end
  endtask

  task automatic test_b_offset();
    set_defaults();
    bus.cfg_frame_period = 200;
    bus.cfg_b_offset     = 50;
    set_gate(0, 40, 30);
    set_gate(2, 95, 200);
    run_cfg();
    capture_frame(200, -1);
    total++; if (cap_ftype !== 2'b01) begin bad++; $display("FAIL boff_ftype_a got=%b want=01", cap_ftype); end
    total++; if (cap_gate[0][39] !== 1'b0 || cap_gate[0][40] !== 1'b1) begin bad++; $display("FAIL boff_a_open got=%b%b want=01", cap_gate[0][39], cap_gate[0][40]); end
    total++; if (cap_gate[0][69] !== 1'b1 || cap_gate[0][70] !== 1'b0) begin bad++; $display("FAIL boff_a_close got=%b%b want=10", cap_gate[0][69], cap_gate[0][70]); end
    total++; if (ones(cap_gate[2], 0, 199) !== 10) begin bad++; $display("FAIL boff_a_trunc got=%0d want=10", ones(cap_gate[2], 0, 199)); end
    capture_frame(200, -1);
    total++; if (cap_ftype !== 2'b10) begin bad++; $display("FAIL boff_ftype_b got=%b want=10", cap_ftype); end
    total++; if (cap_gate[0][89] !== 1'b0 || cap_gate[0][90] !== 1'b1) begin bad++; $display("FAIL boff_b_open got=%b%b want=01", cap_gate[0][89], cap_gate[0][90]); end
    total++; if (cap_gate[0][99] !== 1'b1 || cap_gate[0][100] !== 1'b0) begin bad++; $display("FAIL boff_b_trunc got=%b%b want=10", cap_gate[0][99], cap_gate[0][100]); end
    total++; if (ones(cap_gate[0], 0, 199) !== 20) begin bad++; $display("FAIL boff_b_cnt got=%0d want=20", ones(cap_gate[0], 0, 199)); end
    total++; if (ones(cap_gate[2], 0, 199) !== 0) begin bad++; $display("FAIL boff_b_past_end got=%0d want=0", ones(cap_gate[2], 0, 199)); end
  endtask

  task automatic test_reload();
    set_defaults();
    run_cfg();
    bus.cfg_laser_width = 20;
    capture_frame(1000, 300);
    total++; if (cap_pend[100] !== 1'b0) begin bad++; $display("FAIL reload_pend_before got=%b want=0", cap_pend[100]); end
    total++; if (cap_pend[350] !== 1'b1) begin bad++; $display("FAIL reload_pend_mid got=%b want=1", cap_pend[350]); end
    total++; if (cap_pend[999] !== 1'b1) begin bad++; $display("FAIL reload_pend_end got=%b want=1", cap_pend[999]); end
    total++; if (cap_laser[504] !== 1'b1 || cap_laser[505] !== 1'b0) begin bad++; $display("FAIL reload_old_width got=%b%b want=10", cap_laser[504], cap_laser[505]); end
    capture_frame(1000, -1);
    total++; if (cap_pend[0] !== 1'b0) begin bad++; $display("FAIL reload_pend_clear got=%b want=0", cap_pend[0]); end
    total++; if (cap_laser[19] !== 1'b1 || cap_laser[20] !== 1'b0) begin bad++; $display("FAIL reload_new_width got=%b%b want=10", cap_laser[19], cap_laser[20]); end
    total++; if (ones(cap_laser, 0, 999) !== 200) begin bad++; $display("FAIL reload_laser_cnt got=%0d want=200", ones(cap_laser, 0, 999)); end
  endtask

  task automatic test_clamp();
    set_defaults();
    bus.cfg_frame_period = 200;
    bus.cfg_trig_width   = 2000;
    bus.cfg_laser_width  = 150;
    run_cfg();
    capture_frame(200, -1);
    total++; if (ones(cap_trig, 0, 199) !== 200) begin bad++; $display("FAIL clamp_trig got=%0d want=200", ones(cap_trig, 0, 199)); end
    total++; if (ones(cap_laser, 0, 199) !== 200) begin bad++; $display("FAIL clamp_laser got=%0d want=200", ones(cap_laser, 0, 199)); end
    bus.cfg_laser_period = 0;
    bus.cfg_laser_width  = 5;
    run_cfg();
    capture_frame(200, -1);
    total++; if (ones(cap_laser, 0, 199) !== 0) begin bad++; $display("FAIL clamp_lp0_laser got=%0d want=0", ones(cap_laser, 0, 199)); end
    total++; if (ones(cap_gate[0], 0, 199) !== 0) begin bad++; $display("FAIL clamp_lp0_gate got=%0d want=0", ones(cap_gate[0], 0, 199)); end
  endtask

  task automatic test_disable();
    int seen = 0;
    set_defaults();
    run_cfg();
    capture_frame(1000, -1);
    bus.enable = 1'b0;
    step();
    step();
    total++; if (bus.trig_pulse !== 1'b0 || bus.laser_pulse !== 1'b0) begin bad++; $display("FAIL disable_pulses got=%b%b want=00", bus.trig_pulse, bus.laser_pulse); end
    for (int n = 0; n < 50; n++) begin
      if (bus.frame_start === 1'b1) seen++;
      step();
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL disable_no_start got=%0d want=0", seen); end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    int seen  = 0;
    set_defaults();
    set_gate(0, 2, 8);
    run_cfg();
    while (bus.frame_start !== 1'b1 && guard < 3000) begin step(); guard++; end
    repeat (3) step();
    total++; if (bus.trig_pulse !== 1'b1 || bus.laser_pulse !== 1'b1 || bus.gate_pulse[0] !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre got=%b%b%b want=111", bus.trig_pulse, bus.laser_pulse, bus.gate_pulse[0]);
    end
    rst = 1'b1;
    #1;
    total++; if (bus.trig_pulse !== 1'b0 || bus.laser_pulse !== 1'b0 || bus.gate_pulse !== 4'h0) begin
      bad++; $display("FAIL rstmid_async got=%b%b%h want=000", bus.trig_pulse, bus.laser_pulse, bus.gate_pulse);
    end
    total++; if (bus.frame_type !== 2'b00 || bus.param_pending !== 1'b0) begin
      bad++; $display("FAIL rstmid_ftype got=%b/%b want=00/0", bus.frame_type, bus.param_pending);
    end
    step();
    rst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (bus.frame_start === 1'b1 || bus.trig_pulse === 1'b1) seen++;
      step();
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_no_restart got=%0d want=0", seen); end
    run_cfg();
    capture_frame(1000, -1);
    total++; if (cap_ftype !== 2'b01 || ones(cap_trig, 0, 999) !== 10) begin
      bad++; $display("FAIL rstmid_restart got=%b/%0d want=01/10", cap_ftype, ones(cap_trig, 0, 999));
    end
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    bus.enable = 1'b0;
    bus.load_param = 1'b0;
    set_defaults();
    test_reset();
    test_basic();
    test_background();
    test_step();
    test_b_offset();
    test_reload();
    test_clamp();
    test_disable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
